// File: rtl/bs_fixed_pkg.sv
// Shared Q6.10 fixed-point definitions for the sqrt table reader and writer.
// Also holds the rounding step that turns a floor root and remainder into a nearest-integer root.
package bs_fixed_pkg;

  typedef logic signed [15:0] q6_10_t;

  localparam int Q_FRAC          = 10;
  localparam int Q_ONE           = 1024;
  localparam int SQRT_STEP_SHIFT = 5;
  localparam int SQRT_DEPTH      = 513;
  localparam int SQRT_ADDR_W     = 10;
  localparam int SQRT_RAD_W      = SQRT_ADDR_W + SQRT_STEP_SHIFT + Q_FRAC;
  localparam int SQRT_ROOT_W     = 13;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ITER  = 3'd2,
    ST_ROUND = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } stw_state_e;

  // sqrt(R) >= q + 0.5 exactly when R - q*q > q, so the remainder decides the round-up.
  function automatic q6_10_t round_root(input logic [SQRT_ROOT_W-1:0] q, input logic [15:0] r);
    logic [15:0] q_ext;
    q_ext = {3'b000, q};
    if (r > q_ext) begin
      round_root = q6_10_t'(q_ext + 16'd1);
    end else begin
      round_root = q6_10_t'(q_ext);
    end
  endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Bit-serial restoring integer square root: 25-bit radicand, 13-bit floor root.
// One root bit per step, MSB first; last flags the 13th (final) step.
module isqrt_seq
  import bs_fixed_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [SQRT_RAD_W-1:0]  radicand,
  input  logic                   step,
  output logic                   last,
  output logic [SQRT_ROOT_W-1:0] root,
  output logic [15:0]            rem
);

  logic [25:0]            rad_q, rad_d;
  logic [SQRT_ROOT_W-1:0] root_q, root_d;
  logic [15:0]            rem_q, rem_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [15:0]            partial_s, trial_s, diff_s;
  logic                   fits_s;

  // Bring down the next radicand bit pair and try the trial subtrahend 4q+1.
  always_comb begin
    partial_s = {rem_q[13:0], rad_q[25:24]};
    trial_s   = {1'b0, root_q, 2'b01};
    diff_s    = partial_s - trial_s;
    fits_s    = (partial_s >= trial_s);
    rad_d     = rad_q;
    root_d    = root_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    if (load) begin
      rad_d  = {1'b0, radicand};
      root_d = {SQRT_ROOT_W{1'b0}};
      rem_d  = 16'd0;
      cnt_d  = 4'd12;
    end else if (step) begin
      rad_d = {rad_q[23:0], 2'b00};
      if (fits_s) begin
        rem_d  = diff_s;
        root_d = {root_q[SQRT_ROOT_W-2:0], 1'b1};
      end else begin
        rem_d  = partial_s;
        root_d = {root_q[SQRT_ROOT_W-2:0], 1'b0};
      end
      if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      rad_d = rad_q;
    end
  end

  // Recurrence state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_q  <= 26'd0;
      root_q <= {SQRT_ROOT_W{1'b0}};
      rem_q  <= 16'd0;
      cnt_q  <= 4'd0;
    end else begin
      rad_q  <= rad_d;
      root_q <= root_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
    end
  end

  assign last = (cnt_q == 4'd0);
  assign root = root_q;
  assign rem  = rem_q;

endmodule

// File: rtl/sqrt_table_writer.sv
// Fills the Q6.10 sqrt lookup memory: one rounded sqrt(a*32/1024) write per address.
// Entries are produced in ascending order over a valid/ready write port that may stall.
module sqrt_table_writer
  import bs_fixed_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [SQRT_ADDR_W-1:0] wr_addr,
  output logic [15:0]            wr_data
);

  localparam logic [SQRT_ADDR_W-1:0] LAST_ADDR = SQRT_ADDR_W'(SQRT_DEPTH - 1);

  stw_state_e             state_q, state_d;
  logic [SQRT_ADDR_W-1:0] addr_q, addr_d;
  logic [SQRT_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  q6_10_t                 wr_data_q, wr_data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   wr_valid_q, wr_valid_d;

  logic                   core_last_s;
  logic [SQRT_ROOT_W-1:0] core_root_s;
  logic [15:0]            core_rem_s;

  isqrt_seq u_isqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_q == ST_LOAD),
    .radicand ({addr_q, 15'd0}),
    .step     (state_q == ST_ITER),
    .last     (core_last_s),
    .root     (core_root_s),
    .rem      (core_rem_s)
  );

  // Next state; flag outputs are decoded from the next state so they register alongside it.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = {SQRT_ADDR_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: state_d = ST_ITER;
      ST_ITER: begin
        if (core_last_s) begin
          state_d = ST_ROUND;
        end else begin
          state_d = ST_ITER;
        end
      end
      ST_ROUND: begin
        wr_addr_d = addr_q;
        wr_data_d = round_root(core_root_s, core_rem_s);
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        if (!wr_ready) begin
          state_d = ST_WRITE;
        end else if (addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + {{(SQRT_ADDR_W-1){1'b0}}, 1'b1};
          state_d = ST_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    wr_valid_d = (state_d == ST_WRITE);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= {SQRT_ADDR_W{1'b0}};
      wr_addr_q  <= {SQRT_ADDR_W{1'b0}};
      wr_data_q  <= 16'sd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_valid_q <= wr_valid_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_sqrt_table_writer.sv
// Directed bench for sqrt_table_writer: spot-value table, golden sweep, timing,
// backpressure, start-while-busy and mid-build reset sequences.
module tb_sqrt_table_writer;

  typedef struct {
    int addr;
    int exp;
  } spot_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        wr_valid;
  logic        wr_ready;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int cap_addr [513];
  int cap_data [513];
  int cap_rel  [513];
  int wr_cnt, extra_w, done_cnt, done_rel, s_cyc;
  spot_t spots [8];

  sqrt_table_writer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every accepted write and every done pulse, timed relative to the start edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_valid && wr_ready) begin
        if (wr_cnt < 513) begin
          cap_addr[wr_cnt] = int'(wr_addr);
          cap_data[wr_cnt] = int'(wr_data);
          cap_rel[wr_cnt]  = cyc + 1 - s_cyc;
        end else begin
          extra_w = extra_w + 1;
        end
        wr_cnt = wr_cnt + 1;
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_rel = cyc + 1 - s_cyc;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int golden(input int a);
    return int'($sqrt(real'(a) * 32768.0));
  endfunction

  task automatic begin_build();
    wr_cnt   = 0;
    extra_w  = 0;
    done_cnt = 0;
    done_rel = 0;
    @(posedge clk);
    #1 start = 1'b1;
    s_cyc = cyc + 1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_done_rel);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 9000) begin
      @(posedge clk);
      n = n + 1;
    end
    check({name, " done seen"}, int'(done_cnt > 0), 1);
    repeat (5) @(posedge clk);
    check({name, " done count"}, done_cnt, 1);
    check({name, " done cycle"}, done_rel, exp_done_rel);
    check({name, " write count"}, wr_cnt, 513);
    check({name, " extra writes"}, extra_w, 0);
    check({name, " busy after done"}, int'(busy), 0);
  endtask

  task automatic verify_table(input string name);
    int max_v;
    max_v = 0;
    for (int a = 0; a < 513; a++) begin
      check({name, " order"}, cap_addr[a], a);
      check({name, " sweep"}, cap_data[a], golden(a));
      if (cap_data[a] > max_v) max_v = cap_data[a];
    end
    check({name, " max value"}, int'(max_v <= 4096), 1);
  endtask

  task automatic wait_write_of(input int a, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 9000) begin
      @(posedge clk);
      #1;
      if (wr_valid && int'(wr_addr) == a) ok = 1'b1;
      n = n + 1;
    end
  endtask

  initial begin
    bit ok;
    int bad;
    int held;
    spots[0] = '{0, 0};
    spots[1] = '{1, 181};
    spots[2] = '{2, 256};
    spots[3] = '{3, 314};
    spots[4] = '{16, 724};
    spots[5] = '{32, 1024};
    spots[6] = '{128, 2048};
    spots[7] = '{512, 4096};
    wr_cnt = 0; extra_w = 0; done_cnt = 0; done_rel = 0; s_cyc = 0;

    rst_n = 1'b0; start = 1'b0; wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset outputs", int'({busy, done, wr_valid, wr_addr, wr_data}), 0);
    #2 rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (wr_valid || busy || done) bad = bad + 1;
    end
    check("idle quiet", bad, 0);

    // Plain build: values, order and latency.
    begin_build();
    @(negedge clk);
    check("busy after start", int'(busy), 1);
    wait_done("build1", 8209);
    check("first accept", cap_rel[0], 16);
    check("second accept", cap_rel[1], 32);
    check("last accept", cap_rel[512], 8208);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("spot addr%0d", spots[i].addr), cap_data[spots[i].addr], spots[i].exp);
    end
    verify_table("build1");

    // A start pulse mid-build must not disturb anything.
    begin_build();
    repeat (48) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("busy start", 8209);
    check("busy start last accept", cap_rel[512], 8208);
    verify_table("busy start");

    // Seven cycles of backpressure on address 32.
    begin_build();
    wait_write_of(32, ok);
    check("bp reached addr32", int'(ok), 1);
    wr_ready = 1'b0;
    held = 0;
    repeat (7) begin
      @(posedge clk);
      #1;
      if (wr_valid && int'(wr_addr) == 32 && int'(wr_data) == 1024) held = held + 1;
    end
    wr_ready = 1'b1;
    check("bp held stable", held, 7);
    wait_done("backpressure", 8216);
    check("bp addr31 accept", cap_rel[31], 512);
    check("bp addr32 accept", cap_rel[32], 535);
    check("bp last accept", cap_rel[512], 8215);
    check("bp addr32 data", cap_data[32], 1024);
    verify_table("backpressure");

    // Reset during the write of address 100, then rebuild from scratch.
    begin_build();
    wait_write_of(100, ok);
    check("rst reached addr100", int'(ok), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async clear", int'({busy, done, wr_valid, wr_addr, wr_data}), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    held = wr_cnt;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (wr_valid || busy) bad = bad + 1;
    end
    check("no writes after reset", wr_cnt - held + bad, 0);
    begin_build();
    wait_done("rebuild", 8209);
    check("rebuild first addr", cap_addr[0], 0);
    check("rebuild first accept", cap_rel[0], 16);
    verify_table("rebuild");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
